// File: rtl/sad_pe_min.sv
`default_nettype none
// ============================================================================
// Module      : sad_pe_min
// Description : Systolic SAD processing element. It accumulates saturating
//               |ref - search| over a block and tracks the best candidate.
// Revision    : 1.0
// ============================================================================
module sad_pe_min #(
  parameter int PIX_W    = 8,
  parameter int ACC_W    = 16,
  parameter int BLK_PIX  = 256,
  parameter int NUM_CAND = 256,
  localparam int CNT_W   = $clog2(BLK_PIX),
  localparam int IDX_W   = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_newBlk,
  input  logic [PIX_W-1:0] i_refMem,
  input  logic [PIX_W-1:0] i_searchMem1,
  input  logic [PIX_W-1:0] i_searchMem2,
  input  logic             i_s1s2Mux,
  output logic [PIX_W-1:0] o_rPipe,
  output logic [ACC_W-1:0] o_accumulate,
  output logic [ACC_W-1:0] o_sad,
  output logic             o_sadValid,
  output logic [ACC_W-1:0] o_minSad,
  output logic [IDX_W-1:0] o_minIdx,
  output logic             o_minValid
);

  localparam logic [CNT_W-1:0] C_LAST_PIX  = CNT_W'(BLK_PIX - 1);
  localparam logic [IDX_W-1:0] C_LAST_CAND = IDX_W'(NUM_CAND - 1);
  localparam logic [ACC_W-1:0] C_ACC_MAX   = '1;

  logic [PIX_W-1:0] r_rpipe;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sad;
  logic             r_sad_valid;
  logic [ACC_W-1:0] r_min_sad;
  logic [IDX_W-1:0] r_min_idx;
  logic             r_min_valid;
  logic             r_min_empty;
  logic             r_cmp_pend;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_cand;
  logic [IDX_W-1:0] r_tag;

  logic [PIX_W-1:0] w_sel;
  logic [PIX_W:0]   w_diff_ext;
  logic [PIX_W-1:0] w_diff;
  logic [ACC_W-1:0] w_diff_acc;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_sat;
  logic [CNT_W-1:0] w_cnt_eff;
  logic [IDX_W-1:0] w_cand_eff;

  // Absolute difference: the borrow bit of the widened subtraction picks the
  // operand order, so the magnitude always fits in PIX_W bits.
  always_comb begin
    w_sel      = i_s1s2Mux ? i_searchMem1 : i_searchMem2;
    w_diff_ext = {1'b0, i_refMem} - {1'b0, w_sel};
    w_diff     = w_diff_ext[PIX_W] ? (w_sel - i_refMem) : w_diff_ext[PIX_W-1:0];
    w_diff_acc = ACC_W'(w_diff);
    w_sum      = {1'b0, r_acc} + {1'b0, w_diff_acc};
    w_acc_sat  = w_sum[ACC_W] ? C_ACC_MAX : w_sum[ACC_W-1:0];
  end

  // A new block restarts the beat as count 0 of candidate 0 on the same edge.
  always_comb begin
    w_cnt_eff  = i_newBlk ? '0 : r_cnt;
    w_cand_eff = i_newBlk ? '0 : r_cand;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rpipe     <= '0;
      r_acc       <= '0;
      r_sad       <= '0;
      r_sad_valid <= 1'b0;
      r_min_sad   <= C_ACC_MAX;
      r_min_idx   <= '0;
      r_min_valid <= 1'b0;
      r_min_empty <= 1'b1;
      r_cmp_pend  <= 1'b0;
      r_cnt       <= '0;
      r_cand      <= '0;
      r_tag       <= '0;
    end else begin
      r_sad_valid <= 1'b0;
      r_min_valid <= 1'b0;
      r_cmp_pend  <= 1'b0;

      if (i_newBlk) begin
        r_cnt       <= '0;
        r_cand      <= '0;
        r_min_empty <= 1'b1;
        r_min_sad   <= C_ACC_MAX;
        r_min_idx   <= '0;
      end else if (r_cmp_pend) begin
        // Strict less-than keeps the earlier index on ties.
        if (r_min_empty || (r_sad < r_min_sad)) begin
          r_min_sad   <= r_sad;
          r_min_idx   <= r_tag;
          r_min_empty <= 1'b0;
        end
        if (r_tag == C_LAST_CAND) begin
          r_min_valid <= 1'b1;
        end
      end

      if (i_en) begin
        r_rpipe <= i_refMem;
        r_acc   <= (w_cnt_eff == '0) ? w_diff_acc : w_acc_sat;
        if (w_cnt_eff == C_LAST_PIX) begin
          r_cnt       <= '0;
          r_sad       <= w_acc_sat;
          r_sad_valid <= 1'b1;
          r_cmp_pend  <= 1'b1;
          r_tag       <= w_cand_eff;
          r_cand      <= (w_cand_eff == C_LAST_CAND) ? '0 : w_cand_eff + IDX_W'(1);
        end else begin
          r_cnt <= w_cnt_eff + CNT_W'(1);
        end
      end
    end
  end

  assign o_rPipe      = r_rpipe;
  assign o_accumulate = r_acc;
  assign o_sad        = r_sad;
  assign o_sadValid   = r_sad_valid;
  assign o_minSad     = r_min_sad;
  assign o_minIdx     = r_min_idx;
  assign o_minValid   = r_min_valid;

endmodule
`default_nettype wire

// File: tb/tb_sad_pe_min.sv
`default_nettype none
// ============================================================================
// Module      : tb_sad_pe_min
// Description : Self-checking bench for sad_pe_min against a block-level model.
// Revision    : 1.0
// ============================================================================
module tb_sad_pe_min;

  localparam int PIX_W    = 8;
  localparam int ACC_W    = 9;
  localparam int BLK_PIX  = 4;
  localparam int NUM_CAND = 3;
  localparam int IDX_W    = 2;
  localparam int SAT      = (1 << ACC_W) - 1;

  logic             i_clk;
  logic             i_rst;
  logic             i_en;
  logic             i_newBlk;
  logic [PIX_W-1:0] i_refMem;
  logic [PIX_W-1:0] i_searchMem1;
  logic [PIX_W-1:0] i_searchMem2;
  logic             i_s1s2Mux;
  logic [PIX_W-1:0] o_rPipe;
  logic [ACC_W-1:0] o_accumulate;
  logic [ACC_W-1:0] o_sad;
  logic             o_sadValid;
  logic [ACC_W-1:0] o_minSad;
  logic [IDX_W-1:0] o_minIdx;
  logic             o_minValid;

  sad_pe_min #(
    .PIX_W    (PIX_W),
    .ACC_W    (ACC_W),
    .BLK_PIX  (BLK_PIX),
    .NUM_CAND (NUM_CAND)
  ) u_dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_newBlk     (i_newBlk),
    .i_refMem     (i_refMem),
    .i_searchMem1 (i_searchMem1),
    .i_searchMem2 (i_searchMem2),
    .i_s1s2Mux    (i_s1s2Mux),
    .o_rPipe      (o_rPipe),
    .o_accumulate (o_accumulate),
    .o_sad        (o_sad),
    .o_sadValid   (o_sadValid),
    .o_minSad     (o_minSad),
    .o_minIdx     (o_minIdx),
    .o_minValid   (o_minValid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // Model: a candidate's SAD is min(sum of its diffs, SAT); the minimum is
  // the first-seen smallest SAD of the block.
  int m_diffs[$];
  int m_cand, m_ptag, m_psad;
  bit m_pend, m_empty;
  int e_acc, e_sad, e_rpipe, e_min, e_idx;
  bit e_sv, e_mv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit en, input bit nb,
                     input int r, input int a, input int b, input bit mux);
    int sel, d, s;
    i_rst        = rst;
    i_en         = en;
    i_newBlk     = nb;
    i_refMem     = PIX_W'(r);
    i_searchMem1 = PIX_W'(a);
    i_searchMem2 = PIX_W'(b);
    i_s1s2Mux    = mux;
    e_sv = 1'b0;
    e_mv = 1'b0;
    if (rst) begin
      m_diffs.delete();
      m_cand = 0; m_pend = 0; m_empty = 1;
      e_min = SAT; e_idx = 0; e_acc = 0; e_sad = 0; e_rpipe = 0;
    end else begin
      if (m_pend && !nb) begin
        if (m_empty || m_psad < e_min) begin
          e_min = m_psad; e_idx = m_ptag; m_empty = 0;
        end
        if (m_ptag == NUM_CAND - 1) e_mv = 1'b1;
      end
      if (nb) begin
        m_diffs.delete();
        m_cand = 0; m_empty = 1; e_min = SAT; e_idx = 0;
      end
      m_pend = 0;
      if (en) begin
        sel = mux ? a : b;
        d   = (r > sel) ? r - sel : sel - r;
        m_diffs.push_back(d);
        s = 0;
        foreach (m_diffs[k]) s += m_diffs[k];
        e_acc   = (s > SAT) ? SAT : s;
        e_rpipe = r;
        if (m_diffs.size() == BLK_PIX) begin
          e_sad  = e_acc; e_sv = 1'b1;
          m_pend = 1; m_psad = e_acc; m_ptag = m_cand;
          m_cand = (m_cand + 1) % NUM_CAND;
          m_diffs.delete();
        end
      end
    end
    @(posedge i_clk);
    #1;
    check_eq("rpipe", o_rPipe, e_rpipe);
    check_eq("acc", o_accumulate, e_acc);
    check_eq("sad", o_sad, e_sad);
    check_eq("sad_valid", o_sadValid, e_sv);
    check_eq("min_sad", o_minSad, e_min);
    check_eq("min_idx", o_minIdx, e_idx);
    check_eq("min_valid", o_minValid, e_mv);
  endtask

  task automatic beat(input int r, input int a);
    cyc(1'b0, 1'b1, 1'b0, r, a, 0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
  endtask

  task automatic new_blk();
    cyc(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b1);
  endtask

  int ref_t1[4] = '{10, 20, 30, 40};
  int s1_t1[4]  = '{12, 18, 30, 50};
  int acc_t1[4] = '{2, 4, 4, 14};
  int acc_sat[4] = '{255, 510, 511, 511};

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 99, 1, 2, 1'b0);
    check_eq("rst_minSad", o_minSad, SAT);
    check_eq("rst_acc", o_accumulate, 0);

    // Contiguous block with known partial sums
    new_blk();
    for (int i = 0; i < 4; i++) begin
      beat(ref_t1[i], s1_t1[i]);
      check_eq("t1_acc", o_accumulate, acc_t1[i]);
      check_eq("t1_rpipe", o_rPipe, ref_t1[i]);
    end
    check_eq("t1_sad", o_sad, 14);
    check_eq("t1_sadValid", o_sadValid, 1);
    idle();
    check_eq("t1_sadValid_off", o_sadValid, 0);

    // Mux select and absolute value
    cyc(1'b0, 1'b1, 1'b1, 5, 0, 200, 1'b0);
    check_eq("mux_s2", o_accumulate, 195);
    cyc(1'b0, 1'b1, 1'b1, 5, 0, 200, 1'b1);
    check_eq("mux_s1", o_accumulate, 5);

    // Saturation, then restart from own diff
    new_blk();
    for (int i = 0; i < 4; i++) begin
      beat(255, 0);
      check_eq("sat_acc", o_accumulate, acc_sat[i]);
    end
    check_eq("sat_sad", o_sad, 511);
    beat(3, 0);
    check_eq("sat_restart", o_accumulate, 3);

    // Minimum tracking with tie: SADs 40, 25, 25 back-to-back
    new_blk();
    for (int i = 0; i < 4; i++) beat(10, 0);
    for (int c = 0; c < 2; c++) begin
      beat(10, 0);
      for (int i = 0; i < 3; i++) beat(5, 0);
    end
    idle();
    check_eq("min_pulse", o_minValid, 1);
    check_eq("min_val", o_minSad, 25);
    check_eq("min_idx_tie", o_minIdx, 1);
    idle();
    check_eq("min_pulse_once", o_minValid, 0);

    // Stalled beats give identical result
    new_blk();
    for (int i = 0; i < 4; i++) begin
      beat(ref_t1[i], s1_t1[i]);
      idle();
      idle();
      check_eq("stall_acc_hold", o_accumulate, acc_t1[i]);
      check_eq("stall_rpipe_hold", o_rPipe, ref_t1[i]);
    end
    check_eq("stall_sad", o_sad, 14);

    // Abort candidate 1 at beat 2 with newBlk
    new_blk();
    for (int i = 0; i < 4; i++) beat(7, 0);
    beat(1, 0);
    beat(1, 0);
    cyc(1'b0, 1'b1, 1'b1, 9, 0, 0, 1'b1);
    check_eq("abort_minSad", o_minSad, SAT);
    for (int i = 0; i < 3; i++) beat(9, 0);
    check_eq("abort_sad", o_sad, 36);
    idle();
    check_eq("abort_idx", o_minIdx, 0);

    // Reset mid-block
    beat(50, 0);
    beat(60, 0);
    cyc(1'b1, 1'b1, 1'b0, 3, 4, 5, 1'b1);
    check_eq("midrst_acc", o_accumulate, 0);
    check_eq("midrst_rpipe", o_rPipe, 0);

    // newBlk in the final candidate's sadValid cycle suppresses minValid
    new_blk();
    for (int i = 0; i < 12; i++) beat(i * 3, 1);
    cyc(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b1);
    check_eq("nb_no_minValid", o_minValid, 0);
    idle();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      bit rst, en, nb, mux;
      int r, a, b, lim;
      rst = ($urandom_range(0, 199) == 0);
      nb  = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 9) < 7);
      mux = $urandom_range(0, 1);
      lim = ($urandom_range(0, 1) == 0) ? 3 : 255;
      r = $urandom_range(0, lim);
      a = $urandom_range(0, lim);
      b = $urandom_range(0, lim);
      cyc(rst, en, nb, r, a, b, mux);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sad_pe_min.md
Name: sad_pe_min

Overview:
Parametrised successor to the single-channel SAD processing element. It computes |ref − search| per pixel and accumulates with saturation over a block of BLK_PIX pixels. It emits one SAD per candidate position and tracks the minimum SAD and its candidate index across NUM_CAND candidates. It sits in the systolic motion-estimation array and forwards the reference pixel so the next PE sees it one beat later.

Parameters:
PIX_W, 8, pixel width in bits
ACC_W, 16, accumulator/SAD width in bits; must be ≥ PIX_W
BLK_PIX, 256, pixels per candidate block (≥2)
NUM_CAND, 256, candidate positions per reference block (≥1)
Derived localparams: CNT_W = clog2(BLK_PIX), IDX_W = max(1, clog2(NUM_CAND))

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous active-high reset
i_en  in  1  pixel beat valid; all state advances only on i_en=1, except output pulses and the compare stage
i_newBlk  in  1  start of a new reference block; clears the counters and the minimum tracker
i_refMem  in  PIX_W  reference pixel
i_searchMem1  in  PIX_W  search pixel, source 1
i_searchMem2  in  PIX_W  search pixel, source 2
i_s1s2Mux  in  1  1 selects i_searchMem1, 0 selects i_searchMem2
o_rPipe  out  PIX_W  i_refMem registered on i_en beats
o_accumulate  out  ACC_W  running partial SAD
o_sad  out  ACC_W  completed SAD for the last candidate
o_sadValid  out  1  one-cycle pulse when o_sad is updated
o_minSad  out  ACC_W  best SAD for the current reference block
o_minIdx  out  IDX_W  candidate index of o_minSad
o_minValid  out  1  one-cycle pulse when the final candidate's compare is done

Behaviour:
- Reset values: o_rPipe=0, o_accumulate=0, o_sad=0, o_sadValid=0, o_minSad=all ones, o_minIdx=0, o_minValid=0.
- Reset internals: pixel counter=0, candidate index=0, "min empty" flag set, compare-pending cleared. Reset overrides all other inputs, including mid-block.
- Difference: combinational; diff = |ref − sel| computed in PIX_W+1 bits, exact result in PIX_W bits, zero-extended to ACC_W.
- Beat at pixel count 0: o_accumulate <= diff.
- Other beats: o_accumulate <= min(o_accumulate + diff, 2^ACC_W − 1). The add is computed in ACC_W+1 bits. Saturation is sticky until the next count-0 beat.
- Pixel counter increments per i_en beat and wraps BLK_PIX−1 → 0.
- Last beat (count BLK_PIX−1), same edge:
  - o_sad <= saturated final sum;
  - o_sadValid <= 1 for exactly one cycle;
  - candidate tag is latched;
  - candidate index increments, wrapping NUM_CAND−1 → 0.
- Latency: o_sadValid is high in the cycle after the last beat's edge. o_sadValid deasserts the next cycle regardless of i_en.
- Compare stage: in the cycle o_sadValid=1, the next edge updates the minimum when the empty flag is set OR o_sad < o_minSad (strict less-than).
  - Update writes o_minSad <= o_sad and o_minIdx <= latched tag, and clears the empty flag.
  - Ties keep the earlier index.
- Final candidate: when the latched tag = NUM_CAND−1, o_minValid pulses on that compare edge, i.e. one cycle after o_sadValid.
  - o_minSad/o_minIdx are final and held until the next i_newBlk or reset.
- i_newBlk=1 clears the pixel counter, candidate index, empty flag and any pending compare. A pending compare in the same cycle is discarded and o_minValid does not fire.
  - If i_en=1 in the same cycle, that beat is processed as count 0 of candidate 0.
  - If i_newBlk=1 mid-candidate, the partial SAD is abandoned and no o_sadValid is produced.
- i_en=0: counters, o_accumulate and o_rPipe hold. Pending pulses and compares still complete.
- Back-to-back candidates with no bubble are supported. The count-0 beat of candidate k+1 may coincide with the o_sadValid cycle of candidate k.
- o_rPipe updates only on i_en beats, 1-beat delay.

Test Plan:
- BLK_PIX=4, mux=1, ref {10,20,30,40}, s1 {12,18,30,50} contiguous → o_accumulate 2,4,4,14; o_sad=14 with o_sadValid high one cycle after the 4th beat; o_rPipe lags ref by one beat.
- Mux/abs: ref=5, s2=200, s1=0, mux=0 → first-beat diff 195; same with mux=1 → 5.
- Saturation, ACC_W=9, BLK_PIX=4, ref 255 vs 0 → o_accumulate 255, 510, 511, 511; o_sad=511. The next candidate restarts from its own diff.
- Min tracking, NUM_CAND=3, candidate SADs 40, 25, 25 → o_minSad=25, o_minIdx=1 (tie keeps the earlier index); o_minValid one cycle after the third o_sadValid, exactly once.
- Stalls: repeat test 1 with i_en low 2 cycles between each beat → identical o_sad; o_accumulate and o_rPipe hold during gaps.
- Abort/reset:
  - i_newBlk during candidate 1 beat 2 → no o_sadValid for it, minimum cleared, index restarts at 0.
  - i_rst mid-block → all outputs return to reset values next cycle.
  - i_newBlk in the o_sadValid cycle of the final candidate → no o_minValid.
